imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 42 ++++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: widths, state encoding
// and the length classification used when a program header arrives.
package imem_loader_pkg;

  localparam int MAX_WORDS_DEF = 256;
  localparam int INST_W        = 16;
  localparam int BYTE_W        = 8;
  localparam int ADDR_W        = 9;
  localparam int IDX_W         = ADDR_W - 1;
  localparam int LEN_W         = 16;
  localparam int CNT_W         = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    LEN_EMPTY,
    LEN_OK,
    LEN_TOO_BIG
  } len_class_e;

  // Decides what a freshly received program length means for the load.
  function automatic len_class_e classify_len(input logic [LEN_W-1:0] n, input int max_words);
    logic [31:0] w_n;
    w_n = {{(32-LEN_W){1'b0}}, n};
    if (n == '0)
      return LEN_EMPTY;
    else if (w_n > 32'(max_words))
      return LEN_TOO_BIG;
    else
      return LEN_OK;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed program from a byte stream into one of two
// instruction-memory banks, holding the CPU in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fileid,
  imem_loader_if.master    bus,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  state_e            r_state;
  logic              r_bank;
  logic [IDX_W-1:0]  r_index;
  logic [CNT_W-1:0]  r_words;
  logic [LEN_W-1:0]  r_len;
  logic [BYTE_W-1:0] r_hi;
  logic [BYTE_W-1:0] r_lo;

  logic              w_rx_ready;
  logic              w_xfer;
  logic              w_last;
  logic [LEN_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_words_inc;

  // Ready is a pure state decode so rx_valid never reaches it combinationally.
  assign w_rx_ready  = (r_state == ST_LEN_HI)  || (r_state == ST_LEN_LO) ||
                       (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO);
  assign w_xfer      = w_rx_ready && bus.rx_valid;
  assign w_len       = {r_len[LEN_W-1:BYTE_W], bus.rx_data};
  assign w_words_inc = r_words + CNT_W'(1);
  assign w_last      = (LEN_W'(w_words_inc) == r_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bank  <= 1'b0;
      r_index <= '0;
      r_words <= '0;
      r_len   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_bank  <= fileid;
            r_index <= '0;
            r_words <= '0;
            r_state <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (w_xfer) begin
            r_len[LEN_W-1:BYTE_W] <= bus.rx_data;
            r_state               <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            case (classify_len(w_len, MAX_WORDS))
              LEN_EMPTY:   r_state <= ST_DONE;
              LEN_TOO_BIG: r_state <= ST_ERR;
              default:     r_state <= ST_DATA_HI;
            endcase
          end
        end
        ST_DATA_HI: begin
          if (w_xfer) begin
            r_hi    <= bus.rx_data;
            r_state <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (w_xfer) begin
            r_lo    <= bus.rx_data;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_words <= w_words_inc;
          // The index parks on the final word so the address never wraps.
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_index <= r_index + IDX_W'(1);
            r_state <= ST_DATA_HI;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_we    = (r_state == ST_WRITE);
  assign bus.imem_addr  = {r_bank, r_index};
  assign bus.imem_wdata = {r_hi, r_lo};

  assign busy         = w_rx_ready || (r_state == ST_WRITE);
  assign done         = (r_state == ST_DONE);
  assign err          = (r_state == ST_ERR);
  assign cpu_rst      = (r_state != ST_DONE);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: streams programs with fixed and random
// handshakes and compares observed memory writes against a reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic             start  = 1'b0;
  logic             fileid = 1'b0;
  logic             cpu_rst;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] words_loaded;

  imem_loader_if bus();

  imem_loader #(.MAX_WORDS(MAX_WORDS_DEF)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fileid       (fileid),
    .bus          (bus.master),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  stim_q[$];
  logic [24:0] obs_q[$];
  logic [24:0] exp_q[$];
  bit          exp_err;
  int          exp_words;
  int          overlap_cnt = 0;

  // Write monitor: records every {addr,data} write and any write cycle with ready high.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      obs_q.push_back({bus.imem_addr, bus.imem_wdata});
      if (bus.rx_ready) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // Reference: a length header then N big-endian words landing at {bank, k}.
  function automatic void model(input logic fid);
    int n;
    n = 32'({stim_q[0], stim_q[1]});
    exp_q.delete();
    exp_err   = (n > MAX_WORDS_DEF);
    exp_words = exp_err ? 0 : n;
    if (!exp_err)
      for (int k = 0; k < n; k++)
        exp_q.push_back({fid, k[7:0], stim_q[2+2*k], stim_q[3+2*k]});
  endfunction

  function automatic void build_stream(input int len, input int nwords);
    logic [15:0] l;
    l = 16'(len);
    stim_q.delete();
    stim_q.push_back(l[15:8]);
    stim_q.push_back(l[7:0]);
    for (int k = 0; k < nwords; k++) begin
      stim_q.push_back(8'($urandom));
      stim_q.push_back(8'($urandom));
    end
  endfunction

  task automatic pulse_start(input logic fid);
    @(negedge clk);
    start  = 1'b1;
    fileid = fid;
    @(negedge clk);
    start  = 1'b0;
    fileid = ~fid;
  endtask

  // Feeds stim_q; poke_at >= 0 raises start while that byte is pending.
  task automatic send_bytes(input bit rnd, input int poke_at, output bit ok);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < stim_q.size() && cyc < 3000) begin
      bus.rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rx_data  = bus.rx_valid ? stim_q[i] : 8'($urandom);
      start        = (i == poke_at);
      fileid       = 1'($urandom);
      hs = bus.rx_valid && bus.rx_ready;
      @(negedge clk);
      if (hs) i++;
      cyc++;
    end
    start = 1'b0;
    ok = (i == stim_q.size());
  endtask

  task automatic wait_end(output bit ok);
    int cyc = 0;
    while (!(done || err) && cyc < 20) begin
      bus.rx_data = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    ok = done || err;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_load(input logic fid, input bit rnd, input int poke_at, output bit ok);
    bit ok1, ok2;
    obs_q.delete();
    overlap_cnt = 0;
    pulse_start(fid);
    send_bytes(rnd, poke_at, ok1);
    wait_end(ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    logic [39:0] got;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    got = {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, busy, done, err, words_loaded, cpu_rst};
    n_vec++;
    if (got !== {1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", got, {1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1});
    end
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    n_vec++;
    if ({busy, bus.rx_ready, cpu_rst} !== 3'b001) begin
      n_err++;
      $display("FAIL idle_no_start: got busy/ready/cpu_rst=%b want 001", {busy, bus.rx_ready, cpu_rst});
    end
  endtask

  task automatic test_basic;
    bit ok;
    stim_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    model(1'b0);
    run_load(1'b0, 1'b0, -1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_timeout: got ok=%0d want 1", ok); end
    n_vec++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes want 2", obs_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_vec++;
        if (obs_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL basic_write%0d: got %h/%h want %h/%h", k, obs_q[k][24:16], obs_q[k][15:0], exp_q[k][24:16], exp_q[k][15:0]);
        end
      end
    end
    n_vec++;
    if ({done, err, cpu_rst, busy, words_loaded, 6'(overlap_cnt)} !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd2, 6'd0}) begin
      n_err++;
      $display("FAIL basic_status: got done/err/cpu_rst/busy/words=%b%b%b%b/%0d overlap=%0d want 1000/2 overlap=0",
               done, err, cpu_rst, busy, words_loaded, overlap_cnt);
    end
  endtask

  task automatic test_bank1_restart;
    bit ok1, ok2;
    obs_q.delete();
    pulse_start(1'b1);
    n_vec++;
    if ({cpu_rst, busy, done, bus.rx_ready, words_loaded} !== {1'b1, 1'b1, 1'b0, 1'b1, 9'd0}) begin
      n_err++;
      $display("FAIL restart_cpu_rst: got cpu_rst/busy/done/ready/words=%b%b%b%b/%0d want 1101/0",
               cpu_rst, busy, done, bus.rx_ready, words_loaded);
    end
    stim_q = {8'h00, 8'h01, 8'hBE, 8'hEF};
    model(1'b1);
    send_bytes(1'b0, -1, ok1);
    wait_end(ok2);
    n_vec++;
    if (!(ok1 && ok2) || obs_q.size() != 1 || exp_q.size() != 1) begin
      n_err++;
      $display("FAIL bank1_count: got %0d writes ok=%0d want 1 write", obs_q.size(), ok1 && ok2);
    end else begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL bank1_write: got %h/%h want %h/%h", obs_q[0][24:16], obs_q[0][15:0], exp_q[0][24:16], exp_q[0][15:0]);
      end
    end
  endtask

  task automatic test_zero_len;
    bit ok;
    logic fid;
    fid = 1'($urandom);
    build_stream(0, 0);
    model(fid);
    run_load(fid, 1'b0, -1, ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL zero_len_writes: got %0d writes ok=%0d want %0d", obs_q.size(), ok, exp_q.size());
    end
    n_vec++;
    if ({done, err, cpu_rst, busy, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 9'(exp_words)}) begin
      n_err++;
      $display("FAIL zero_len_status: got %b%b%b%b/%0d want 1000/%0d", done, err, cpu_rst, busy, words_loaded, exp_words);
    end
  endtask

  task automatic test_too_long;
    bit ok;
    logic fid;
    fid = 1'($urandom);
    build_stream(MAX_WORDS_DEF + 1, 0);
    model(fid);
    run_load(fid, 1'b0, -1, ok);
    n_vec++;
    if (!ok || !exp_err || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL too_long_writes: got %0d writes ok=%0d want 0", obs_q.size(), ok);
    end
    n_vec++;
    if ({done, err, cpu_rst, busy, bus.rx_ready} !== 5'b01100) begin
      n_err++;
      $display("FAIL too_long_status: got done/err/cpu_rst/busy/ready=%b want 01100", {done, err, cpu_rst, busy, bus.rx_ready});
    end
    fid = 1'($urandom);
    build_stream(1, 1);
    model(fid);
    run_load(fid, 1'b0, -1, ok);
    n_vec++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_err++;
      $display("FAIL err_recover: got %0d writes first=%h want 1 write %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 25'h0, exp_q[0]);
    end
    n_vec++;
    if ({done, err, cpu_rst, words_loaded} !== {1'b1, 1'b0, 1'b0, 9'd1}) begin
      n_err++;
      $display("FAIL err_recover_status: got %b%b%b/%0d want 100/1", done, err, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_max_len;
    bit ok;
    build_stream(MAX_WORDS_DEF, MAX_WORDS_DEF);
    model(1'b1);
    run_load(1'b1, 1'b0, -1, ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL max_len_count: got %0d writes ok=%0d want %0d", obs_q.size(), ok, exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_vec++;
        if (obs_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL max_len_write%0d: got %h want %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
    n_vec++;
    if ({done, words_loaded} !== {1'b1, 9'(exp_words)}) begin
      n_err++;
      $display("FAIL max_len_status: got done=%b words=%0d want 1/%0d", done, words_loaded, exp_words);
    end
  endtask

  task automatic test_random_valid;
    bit ok;
    logic fid;
    int n;
    for (int it = 0; it < 8; it++) begin
      fid = 1'($urandom);
      n = $urandom_range(1, 12);
      build_stream(n, n);
      model(fid);
      run_load(fid, 1'b1, $urandom_range(2, 2 + 2 * n - 1), ok);
      n_vec++;
      if (!ok || obs_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d writes ok=%0d want %0d", it, obs_q.size(), ok, exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          n_vec++;
          if (obs_q[k] !== exp_q[k]) begin
            n_err++;
            $display("FAIL rand%0d_write%0d: got %h want %h", it, k, obs_q[k], exp_q[k]);
          end
        end
      end
      n_vec++;
      if ({done, err, cpu_rst, words_loaded, 6'(overlap_cnt)} !== {1'b1, 1'b0, 1'b0, 9'(exp_words), 6'd0}) begin
        n_err++;
        $display("FAIL rand%0d_status: got %b%b%b/%0d overlap=%0d want 100/%0d overlap=0",
                 it, done, err, cpu_rst, words_loaded, overlap_cnt, exp_words);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    logic [39:0] got;
    build_stream(3, 3);
    model(1'b0);
    obs_q.delete();
    pulse_start(1'b0);
    stim_q = stim_q[0:3];
    send_bytes(1'b0, -1, ok);
    n_vec++;
    if (!ok || bus.imem_we !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_first_write: got imem_we=%b ok=%0d want 1", bus.imem_we, ok);
    end
    #2 rst = 1'b0;
    #1;
    got = {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, busy, done, err, words_loaded, cpu_rst};
    n_vec++;
    if (got !== {1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_async: got %h want %h", got, {1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1});
    end
    for (int c = 0; c < 14; c++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      if (c == 4) rst = 1'b1;
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_err++;
      $display("FAIL midrst_writes: got %0d writes first=%h want 1 write %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 25'h0, exp_q[0]);
    end
    n_vec++;
    if ({busy, done, cpu_rst, words_loaded} !== {1'b0, 1'b0, 1'b1, 9'd0}) begin
      n_err++;
      $display("FAIL midrst_idle: got busy/done/cpu_rst=%b%b%b words=%0d want 001/0", busy, done, cpu_rst, words_loaded);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_bank1_restart();
    test_zero_len();
    test_too_long();
    test_max_len();
    test_random_valid();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish within budget");
    $fatal(1, "watchdog expired");
  end

endmodule
